// File: rtl/write_back_buffer.sv
// Write-back buffer: a small FIFO of evicted dirty cache lines waiting for memory.
// It merges repeat writes to the same line and answers fetch-path probes.
module write_back_buffer #(
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wbValid,
  output logic                       wbReady,
  input  logic [ADDRESS_WIDTH-1:0]   writeBackAddress,
  input  logic [8*BLOCK_SIZE-1:0]    writeBackData,
  output logic                       memValid,
  input  logic                       memReady,
  output logic [ADDRESS_WIDTH-1:0]   memAddress,
  output logic [8*BLOCK_SIZE-1:0]    memData,
  input  logic                       lookupValid,
  input  logic [ADDRESS_WIDTH-1:0]   lookupAddress,
  output logic                       lookupHit,
  output logic [8*BLOCK_SIZE-1:0]    lookupData,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int OFF = $clog2(BLOCK_SIZE);
  localparam int LW  = ADDRESS_WIDTH - OFF;
  localparam int DW  = 8 * BLOCK_SIZE;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  logic [LW-1:0] lineAddr [DEPTH];
  logic [DW-1:0] lineData [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic [LW-1:0] wbLine;
  logic [LW-1:0] lkLine;
  logic          accept;
  logic          pop;
  logic          alloc;
  logic          coalesceHit;
  logic [PW-1:0] coalesceIdx;
  logic          storedHit;
  logic [DW-1:0] storedData;
  logic [PW-1:0] scanIdx;
  logic          bypassHit;
  logic          unusedOffsetBits;

  assign wbLine   = writeBackAddress[ADDRESS_WIDTH-1:OFF];
  assign lkLine   = lookupAddress[ADDRESS_WIDTH-1:OFF];
  assign unusedOffsetBits = ^{writeBackAddress[OFF-1:0], lookupAddress[OFF-1:0]};

  assign wbReady  = (count != CW'(DEPTH));
  assign memValid = (count != '0);
  assign accept   = wbValid && wbReady;
  assign pop      = memValid && memReady;
  assign alloc    = accept && !coalesceHit;

  assign memAddress = {lineAddr[head], {OFF{1'b0}}};
  assign memData    = lineData[head];

  // Scan oldest to newest so the newest copy wins when a popped head and a
  // freshly allocated tail briefly share a line address.
  always_comb begin
    coalesceHit = 1'b0;
    coalesceIdx = '0;
    storedHit   = 1'b0;
    storedData  = '0;
    scanIdx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scanIdx = head + PW'(k);
      if (CW'(k) < count) begin
        if (lineAddr[scanIdx] == wbLine && !(pop && k == 0)) begin
          coalesceHit = 1'b1;
          coalesceIdx = scanIdx;
        end
        if (lineAddr[scanIdx] == lkLine) begin
          storedHit  = 1'b1;
          storedData = lineData[scanIdx];
        end
      end
    end
  end

  assign bypassHit = accept && (wbLine == lkLine);

  // Entry storage needs no reset; reset only blocks writes in its cycle.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (coalesceHit) begin
        lineData[coalesceIdx] <= writeBackData;
      end else begin
        lineAddr[tail] <= wbLine;
        lineData[tail] <= writeBackData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      lookupHit  <= 1'b0;
      lookupData <= '0;
    end else begin
      if (alloc) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      if (alloc && !pop) begin
        count <= count + CW'(1);
      end else if (!alloc && pop) begin
        count <= count - CW'(1);
      end
      lookupHit <= lookupValid && (bypassHit || storedHit);
      if (lookupValid && (bypassHit || storedHit)) begin
        lookupData <= bypassHit ? writeBackData : storedData;
      end
    end
  end

endmodule

// File: tb/tb_write_back_buffer.sv
// Bench for write_back_buffer: directed scenarios then random traffic, all
// compared against a queue-based model of the buffered lines.
module tb_write_back_buffer;

  localparam int BS    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int OFF   = 5;
  localparam int DW    = 8 * BS;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wbValid;
  logic          wbReady;
  logic [AW-1:0] writeBackAddress;
  logic [DW-1:0] writeBackData;
  logic          memValid;
  logic          memReady;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memData;
  logic          lookupValid;
  logic [AW-1:0] lookupAddress;
  logic          lookupHit;
  logic [DW-1:0] lookupData;
  logic [CW-1:0] count;

  typedef struct {
    logic [AW-OFF-1:0] line;
    logic [DW-1:0]     data;
  } entryT;

  entryT         modelQ[$];
  int            testsRun  = 0;
  int            failCount = 0;
  logic          expLkHit;
  logic [DW-1:0] expLkData;

  write_back_buffer #(.BLOCK_SIZE(BS), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wbValid(wbValid), .wbReady(wbReady),
    .writeBackAddress(writeBackAddress), .writeBackData(writeBackData),
    .memValid(memValid), .memReady(memReady),
    .memAddress(memAddress), .memData(memData),
    .lookupValid(lookupValid), .lookupAddress(lookupAddress),
    .lookupHit(lookupHit), .lookupData(lookupData),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] randData();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Checks queue-visible outputs, then advances one clock alongside the model.
  task automatic applyStimulus(input logic wbV, input logic [AW-1:0] wbA,
                               input logic [DW-1:0] wbD, input logic memR,
                               input logic lkV, input logic [AW-1:0] lkA);
    int   sz;
    int   idx;
    logic doPop;
    logic doAcc;
    logic found;
    logic [DW-1:0] foundData;
    wbValid = wbV; writeBackAddress = wbA; writeBackData = wbD;
    memReady = memR; lookupValid = lkV; lookupAddress = lkA;
    #1;
    sz = modelQ.size();
    checkOutput("count", count, sz);
    checkOutput("wbReady", wbReady, sz != DEPTH);
    checkOutput("memValid", memValid, sz != 0);
    if (sz != 0) begin
      checkOutput("memAddress", memAddress, {modelQ[0].line, 5'b0});
      checkOutput("memData", memData, modelQ[0].data);
    end
    doPop = (sz != 0) && memR;
    doAcc = wbV && (sz != DEPTH);
    found = 1'b0;
    foundData = '0;
    if (lkV) begin
      if (doAcc && wbA[AW-1:OFF] == lkA[AW-1:OFF]) begin
        found = 1'b1;
        foundData = wbD;
      end else begin
        for (int i = sz - 1; i >= 0; i--) begin
          if (modelQ[i].line == lkA[AW-1:OFF]) begin
            found = 1'b1;
            foundData = modelQ[i].data;
            break;
          end
        end
      end
    end
    expLkHit = found;
    if (found) expLkData = foundData;
    if (doAcc) begin
      idx = -1;
      for (int i = sz - 1; i >= (doPop ? 1 : 0); i--) begin
        if (modelQ[i].line == wbA[AW-1:OFF]) begin
          idx = i;
          break;
        end
      end
      if (idx >= 0) modelQ[idx].data = wbD;
      else modelQ.push_back('{wbA[AW-1:OFF], wbD});
    end
    if (doPop) void'(modelQ.pop_front());
    @(posedge clk);
    #1;
    checkOutput("lookupHit", lookupHit, expLkHit);
    checkOutput("lookupData", lookupData, expLkData);
    @(negedge clk);
  endtask

  // Reset is asserted with live handshakes to show it overrides them.
  task automatic applyReset(input logic memR);
    rst = 1'b1; wbValid = 1'b1; writeBackAddress = 32'h700;
    writeBackData = randData(); memReady = memR;
    lookupValid = 1'b1; lookupAddress = 32'h700;
    @(posedge clk);
    #1;
    rst = 1'b0; wbValid = 1'b0; memReady = 1'b0; lookupValid = 1'b0;
    modelQ.delete();
    expLkHit = 1'b0;
    expLkData = '0;
    checkOutput("rstCount", count, 0);
    checkOutput("rstMemValid", memValid, 0);
    checkOutput("rstWbReady", wbReady, 1);
    checkOutput("rstLookupHit", lookupHit, 0);
    checkOutput("rstLookupData", lookupData, 0);
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] dA, dB, dC, dD;
    logic [AW-1:0] addr;
    rst = 1'b0; wbValid = 1'b0; writeBackAddress = '0; writeBackData = '0;
    memReady = 1'b0; lookupValid = 1'b0; lookupAddress = '0;
    applyReset(1'b0);

    // Fill to capacity while memory stalls, then offer one more line.
    applyStimulus(1, 32'h100, randData(), 0, 0, 0);
    applyStimulus(1, 32'h200, randData(), 0, 0, 0);
    applyStimulus(1, 32'h300, randData(), 0, 0, 0);
    applyStimulus(1, 32'h400, randData(), 0, 0, 0);
    checkOutput("fillCount", count, 4);
    checkOutput("fillWbReady", wbReady, 0);
    checkOutput("fillHead", memAddress, 32'h100);
    applyStimulus(1, 32'h500, randData(), 0, 1, 32'h300);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0, 0);

    // Two writes to one line merge into a single entry.
    dA = randData(); dB = randData();
    applyStimulus(1, 32'h120, dA, 0, 0, 0);
    applyStimulus(1, 32'h13C, dB, 0, 0, 0);
    checkOutput("coalesceCount", count, 1);
    checkOutput("coalesceAddr", memAddress, 32'h120);
    checkOutput("coalesceData", memData, dB);
    applyStimulus(0, 0, 0, 1, 0, 0);

    // A write hitting the head while it drains gets its own new entry.
    applyStimulus(1, 32'h100, randData(), 0, 0, 0);
    dC = randData();
    applyStimulus(1, 32'h104, dC, 1, 0, 0);
    checkOutput("collideCount", count, 1);
    checkOutput("collideAddr", memAddress, 32'h100);
    checkOutput("collideData", memData, dC);
    applyStimulus(0, 0, 0, 1, 0, 0);

    // Lookup bypass, lookup of a draining head, then a miss that holds data.
    dD = randData();
    applyStimulus(1, 32'h500, dD, 0, 1, 32'h500);
    checkOutput("bypassHit", lookupHit, 1);
    checkOutput("bypassData", lookupData, dD);
    applyStimulus(0, 0, 0, 1, 1, 32'h51F);
    applyStimulus(0, 0, 0, 0, 1, 32'h600);
    checkOutput("missHoldData", lookupData, dD);

    // Ten enqueue/drain pairs walk the pointers around more than twice.
    for (int i = 0; i < 10; i++) begin
      addr = 32'h1000 + 32'(i) * 32'h40;
      applyStimulus(1, addr, randData(), 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
    end
    checkOutput("wrapCount", count, 0);

    // Reset with three lines held and memory stalled.
    applyStimulus(1, 32'h2000, randData(), 0, 0, 0);
    applyStimulus(1, 32'h2020, randData(), 0, 0, 0);
    applyStimulus(1, 32'h2040, randData(), 0, 0, 0);
    checkOutput("preResetCount", count, 3);
    applyReset(1'b0);

    // Random traffic over a handful of lines to force merges and collisions.
    for (int i = 0; i < 400; i++) begin
      addr = 32'h3000 + 32'($urandom_range(0, 5)) * 32'h20 + 32'($urandom_range(0, 31));
      applyStimulus($urandom_range(0, 9) < 6, addr, randData(),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    32'h3000 + 32'($urandom_range(0, 6)) * 32'h20);
      if (i == 200) applyReset($urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
